arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel.
REQ-002 Parameter NUM_CH, default 4, number of input channels (legal range 2..16).
REQ-003 Derived SEL_W = $clog2(NUM_CH), not user-overridden.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_CH  per-channel valid.
REQ-008 in_ready  output  NUM_CH  per-channel ready.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  input  SEL_W  channel selected in fixed mode.
REQ-011 out_data  output  WIDTH  registered output beat.
REQ-012 out_valid  output  1  output beat present.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_ch  output  SEL_W  source channel of the current output beat.

Function
REQ-015 Single-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1); slot_free = EMPTY or (FULL and out_ready).
REQ-016 Input transfer on channel i = in_valid[i] and in_ready[i]; output transfer = out_valid and out_ready.
REQ-017 in_ready[i] = slot_free and (i == winner); at most one in_ready bit high per cycle; combinational, no register in path.
REQ-018 Fixed mode: winner = sel if in_valid[sel]; sel >= NUM_CH or in_valid[sel]=0 -> no winner, all in_ready low.
REQ-019 Round-robin mode: winner = first i with in_valid[i] set, searching from last_grant+1 upward, wrapping NUM_CH-1 -> 0, with last_grant checked last.
REQ-020 last_grant updates to i only on an input transfer on channel i, in either mode.
REQ-021 On input transfer: next cycle FULL, out_data = in_data[i], out_ch = i; latency exactly 1 cycle.
REQ-022 slot_free with no winner: next cycle EMPTY; out_data and out_ch hold their last values.
REQ-023 FULL and out_ready=0: out_data, out_ch and out_valid hold stable; all in_ready low.
REQ-024 Simultaneous output and input transfer: the new beat replaces the old beat with no bubble; sustained throughput 1 beat/cycle.
REQ-025 mode and sel changes affect arbitration in the same cycle and never alter a beat already in the register.
REQ-026 in_data and in_valid are sampled only for the winning channel.

Reset
REQ-027 RST_N low asynchronously forces out_valid=0, out_data=0, out_ch=0, last_grant=NUM_CH-1, and all in_ready low while asserted.
REQ-028 Reset mid-transfer discards the held beat; the first round-robin grant after reset favours channel 0.

Configuration
REQ-029 Macro ARB_MUX_STATS_EN defined: adds input clr_cnt (1) and output xfer_cnt (16).
REQ-030 xfer_cnt resets to 0, increments on each output transfer, and saturates at 0xFFFF.
REQ-031 clr_cnt=1 zeroes xfer_cnt on the next edge, taking priority over an increment in the same cycle.
REQ-032 Macro ARB_MUX_STATS_EN undefined: clr_cnt, xfer_cnt and the counter logic are absent; all other behaviour is identical.

Verification
REQ-033 Fixed mode, sel=2, in_valid=4'b0100, in_data ch2=0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xA5, out_ch=2.
REQ-034 Round-robin mode, in_valid=4'b1111 held, out_ready=1 after reset -> grants 0,1,2,3,0 on consecutive cycles with no idle cycle.
REQ-035 FULL with out_ready=0 for 3 cycles while in_valid=4'b1111 -> in_ready=0 and out_data stable; out_ready=1 -> the next beat loads the following cycle.
REQ-036 Fixed mode, sel=5 with NUM_CH=4 -> all in_ready low and out_valid falls to 0 after the current beat drains.
REQ-037 RST_N pulsed low mid-stream -> out_valid=0 immediately (asynchronously); the first round-robin grant after release goes to channel 0.
REQ-038 With ARB_MUX_STATS_EN: 70000 output transfers -> xfer_cnt=0xFFFF; clr_cnt asserted together with a transfer -> xfer_cnt=0.

Source files
------------

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-channel fixed/round-robin arbiter feeding a single-entry output register
// Optional transfer counter enabled by defining ARB_MUX_STATS_EN.
module arb_mux #(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
`ifdef ARB_MUX_STATS_EN
    ,
    input  logic                    clr_cnt,
    output logic [15:0]             xfer_cnt
`endif
);

    typedef enum logic {S_EMPTY, S_FULL} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [SEL_W-1:0]   last_q, last_d;

    logic [WIDTH-1:0]   ch_data [NUM_CH];
    logic               slot_free;
    logic               win_valid;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W-1:0]   cand;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_split
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    assign slot_free = (state_q == S_EMPTY) || out_ready;

    // Round-robin scans last_q+1 upward with wrap, so last_q itself is tried last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (!mode) begin
            if (int'(sel) < NUM_CH) begin
                if (in_valid[sel]) begin
                    win_valid = 1'b1;
                    win_idx   = sel;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                cand = SEL_W'((int'(last_q) + k) % NUM_CH);
                if (!win_valid && in_valid[cand]) begin
                    win_valid = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    // Gated by rst_n so no channel sees ready while reset is held.
    always_comb begin
        in_ready = '0;
        if (rst_n && slot_free && win_valid) begin
            in_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;
        if (slot_free) begin
            if (win_valid) begin
                state_d = S_FULL;
                data_d  = ch_data[win_idx];
                ch_d    = win_idx;
                last_d  = win_idx;
            end else begin
                state_d = S_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            last_q  <= SEL_W'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == S_FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

`ifdef ARB_MUX_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Clear wins over a same-cycle increment; count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid && out_ready && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - self-checking bench for arb_mux against a behavioural arbitration model
module tb_arb_mux;
    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic           out_valid, out_ready;
    logic [1:0]     out_ch;

    logic [5*W-1:0] d5_data;
    logic [4:0]     d5_valid, d5_ready;
    logic [2:0]     d5_sel;
    logic [W-1:0]   d5_out_data;
    logic           d5_out_valid, d5_oready;
    logic [2:0]     d5_out_ch;

`ifdef ARB_MUX_STATS_EN
    logic           clr_cnt, clr5;
    logic [15:0]    xfer_cnt, xfer5;
`endif

    arb_mux #(.WIDTH(W), .NUM_CH(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
`ifdef ARB_MUX_STATS_EN
        , .clr_cnt(clr_cnt), .xfer_cnt(xfer_cnt)
`endif
    );

    arb_mux #(.WIDTH(W), .NUM_CH(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(d5_data), .in_valid(d5_valid),
        .in_ready(d5_ready), .mode(1'b0), .sel(d5_sel), .out_data(d5_out_data),
        .out_valid(d5_out_valid), .out_ready(d5_oready), .out_ch(d5_out_ch)
`ifdef ARB_MUX_STATS_EN
        , .clr_cnt(clr5), .xfer_cnt(xfer5)
`endif
    );

    int checks = 0;
    int failures = 0;

    bit       m_full;
    logic [7:0] m_data;
    int       m_ch;
    int       m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_winner();
        if (!mode) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 1; k <= N; k++) begin
            int c = (m_last + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Called at a falling edge with inputs already applied; checks, predicts, advances one cycle.
    task automatic cycle();
        int w;
        bit sf;
        logic [N-1:0] er;
        #1;
        w  = exp_winner();
        sf = !m_full || out_ready;
        er = '0;
        if (sf && w >= 0) er[w] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_ch", 32'(out_ch), m_ch);
        if (sf) begin
            if (w >= 0) begin
                m_full = 1'b1;
                m_data = in_data[w*W +: W];
                m_ch   = w;
                m_last = w;
            end else begin
                m_full = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_d5_ready", 32'(d5_ready), 0);
        chk("rst_d5_valid", 32'(d5_out_valid), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_full = 1'b0;
        m_data = '0;
        m_ch   = 0;
        m_last = N - 1;
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b1; sel = '0; out_ready = 1'b0;
        d5_data = '0; d5_valid = '0; d5_sel = '0; d5_oready = 1'b1;
`ifdef ARB_MUX_STATS_EN
        clr_cnt = 1'b0; clr5 = 1'b0;
`endif
        @(negedge clk);
        in_valid = 4'hF;
        do_reset();

        // Fixed mode single beat on channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1'b1;
        #1 chk("fixed_ready", 32'(in_ready), 32'h4);
        cycle();
        in_valid = 4'b0000;
        #1 chk("fixed_valid", 32'(out_valid), 1);
        chk("fixed_data", 32'(out_data), 32'hA5);
        chk("fixed_ch", 32'(out_ch), 2);
        cycle();

        // Round-robin from reset: 0,1,2,3,0
        do_reset();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = 32'h4433_2211;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_grant", 32'(in_ready), 32'(1 << (k % 4)));
            cycle();
        end

        // Backpressure holds the beat
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data = $urandom;
            #1 chk("bp_ready", 32'(in_ready), 0);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        cycle();

        // Asynchronous reset mid-stream, then round-robin restarts at channel 0
        #1 chk("pre_rst_valid", 32'(out_valid), 1);
        do_reset();
        mode = 1'b1; in_valid = 4'hF;
        #1 chk("post_rst_grant", 32'(in_ready), 32'h1);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Out-of-range select on a 5-channel instance
        in_valid = '0; out_ready = 1'b1;
        d5_sel = 3'd1; d5_valid = 5'h1F; d5_data = 40'h55_44_33_C3_11;
        #1 chk("d5_load_ready", 32'(d5_ready), 32'h2);
        cycle();
        d5_sel = 3'd5;
        #1 chk("d5_sel5_ready", 32'(d5_ready), 0);
        chk("d5_beat_valid", 32'(d5_out_valid), 1);
        chk("d5_beat_data", 32'(d5_out_data), 32'hC3);
        chk("d5_beat_ch", 32'(d5_out_ch), 1);
        cycle();
        d5_sel = 3'd7;
        #1 chk("d5_drained", 32'(d5_out_valid), 0);
        chk("d5_sel7_ready", 32'(d5_ready), 0);
        cycle();
        chk("d5_data_hold", 32'(d5_out_data), 32'hC3);

`ifdef ARB_MUX_STATS_EN
        do_reset();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        #1 chk("cnt_reset", 32'(xfer_cnt), 0);
        repeat (3) @(negedge clk);
        #1 chk("cnt_two", 32'(xfer_cnt), 2);
        repeat (70000) @(negedge clk);
        #1 chk("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1 chk("cnt_clr", 32'(xfer_cnt), 0);
        @(negedge clk);
        #1 chk("cnt_after_clr", 32'(xfer_cnt), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
